// File: rtl/pe_array_sched.sv
// Sequences one interleaved operand stream onto NUM_PE PEs (registered, 1-cycle latency) and
// drains their results in index order; op_ready only during FEED, the drain stalls on res_ready.
module pe_array_sched #(
  parameter int NUM_PE = 8,
  parameter int DW     = 8,
  parameter int CW     = 32,
  parameter int LEN_W  = 16,
  localparam int IW    = $clog2(NUM_PE)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [LEN_W-1:0]     i_vec_len,
  output logic                 o_busy,
  output logic                 o_done,
  input  logic                 i_op_valid,
  output logic                 o_op_ready,
  input  logic [DW-1:0]        i_op_a,
  input  logic [DW-1:0]        i_op_b,
  output logic [DW-1:0]        o_pe_a,
  output logic [DW-1:0]        o_pe_b,
  output logic [NUM_PE-1:0]    o_pe_in_valid,
  output logic [NUM_PE-1:0]    o_pe_store,
  input  logic [NUM_PE-1:0]    i_pe_out_valid,
  input  logic [NUM_PE*CW-1:0] i_pe_c,
  output logic [NUM_PE-1:0]    o_pe_out_resp,
  output logic                 o_res_valid,
  input  logic                 i_res_ready,
  output logic [CW-1:0]        o_res_data,
  output logic [IW-1:0]        o_res_idx
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FEED  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;
  localparam logic [IW-1:0] LAST_PE = IW'(NUM_PE - 1);

  logic [1:0]        r_state;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_elem;
  logic [IW-1:0]     r_ptr;
  logic [IW-1:0]     r_dptr;
  logic [DW-1:0]     r_pe_a;
  logic [DW-1:0]     r_pe_b;
  logic [NUM_PE-1:0] r_in_valid;
  logic [NUM_PE-1:0] r_store;
  logic [NUM_PE-1:0] r_resp;

  logic              w_beat;
  logic              w_last_term;
  logic              w_last_beat;
  logic              w_res_valid;
  logic              w_res_hs;
  logic [NUM_PE-1:0] w_ptr_oh;
  logic [CW-1:0]     w_res_data;

  assign w_beat      = (r_state == S_FEED) & i_op_valid;
  assign w_last_term = (r_elem == r_len - LEN_W'(1));
  assign w_last_beat = w_beat & w_last_term & (r_ptr == LAST_PE);
  assign w_ptr_oh    = NUM_PE'(1) << r_ptr;
  // The array clears out_valid one cycle after resp, so hold off while resp is in flight.
  assign w_res_valid = (r_state == S_DRAIN) & i_pe_out_valid[r_dptr] & ~(|r_resp);
  assign w_res_hs    = w_res_valid & i_res_ready;

  always_comb begin
    w_res_data = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      if (r_dptr == IW'(i)) w_res_data = i_pe_c[i*CW +: CW];
    end
  end

  assign o_busy        = (r_state != S_IDLE);
  assign o_done        = (r_state == S_DONE);
  assign o_op_ready    = (r_state == S_FEED);
  assign o_pe_a        = r_pe_a;
  assign o_pe_b        = r_pe_b;
  assign o_pe_in_valid = r_in_valid;
  assign o_pe_store    = r_store;
  assign o_pe_out_resp = r_resp;
  assign o_res_valid   = w_res_valid;
  assign o_res_data    = w_res_data;
  assign o_res_idx     = r_dptr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_elem     <= '0;
      r_ptr      <= '0;
      r_dptr     <= '0;
      r_pe_a     <= '0;
      r_pe_b     <= '0;
      r_in_valid <= '0;
      r_store    <= '0;
      r_resp     <= '0;
    end else begin
      r_in_valid <= '0;
      r_store    <= '0;
      r_resp     <= '0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_len   <= (i_vec_len == '0) ? LEN_W'(1) : i_vec_len;
            r_elem  <= '0;
            r_ptr   <= '0;
            r_dptr  <= '0;
            r_state <= S_FEED;
          end
        end
        S_FEED: begin
          if (w_beat) begin
            r_pe_a     <= i_op_a;
            r_pe_b     <= i_op_b;
            r_in_valid <= w_ptr_oh;
            r_store    <= w_last_term ? w_ptr_oh : '0;
            if (r_ptr == LAST_PE) begin
              r_ptr  <= '0;
              r_elem <= r_elem + LEN_W'(1);
            end else begin
              r_ptr <= r_ptr + IW'(1);
            end
            if (w_last_beat) begin
              r_dptr  <= '0;
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (w_res_hs) begin
            r_resp <= NUM_PE'(1) << r_dptr;
            if (r_dptr == LAST_PE) r_state <= S_DONE;
            else                   r_dptr  <= r_dptr + IW'(1);
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pe_array_sched.sv
// Randomized bench for pe_array_sched with a job-level reference model and a PE array stand-in.
module tb_pe_array_sched;
  localparam int NP = 8;
  localparam int DW = 8;
  localparam int CW = 32;
  localparam int LW = 16;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic [LW-1:0]  vec_len = '0;
  logic           busy, done, op_ready;
  logic           op_valid = 1'b0;
  logic [DW-1:0]  op_a = '0, op_b = '0;
  logic [DW-1:0]  pe_a, pe_b;
  logic [NP-1:0]  pe_in_valid, pe_store, pe_out_resp;
  logic [NP-1:0]  pe_out_valid;
  logic [NP*CW-1:0] pe_c;
  logic           res_valid;
  logic           res_ready = 1'b0;
  logic [CW-1:0]  res_data;
  logic [2:0]     res_idx;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pe_array_sched #(.NUM_PE(NP), .DW(DW), .CW(CW), .LEN_W(LW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_vec_len(vec_len),
    .o_busy(busy), .o_done(done), .i_op_valid(op_valid), .o_op_ready(op_ready),
    .i_op_a(op_a), .i_op_b(op_b), .o_pe_a(pe_a), .o_pe_b(pe_b),
    .o_pe_in_valid(pe_in_valid), .o_pe_store(pe_store),
    .i_pe_out_valid(pe_out_valid), .i_pe_c(pe_c), .o_pe_out_resp(pe_out_resp),
    .o_res_valid(res_valid), .i_res_ready(res_ready),
    .o_res_data(res_data), .o_res_idx(res_idx)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // PE array stand-in: accumulates, latches result on store, clears valid one cycle after resp.
  logic [CW-1:0] arr_acc [NP];
  logic [CW-1:0] arr_hold[NP];
  logic [NP-1:0] arr_val;
  logic [CW-1:0] got_res [NP];

  assign pe_out_valid = arr_val;
  always_comb begin
    pe_c = '0;
    for (int i = 0; i < NP; i++) pe_c[i*CW +: CW] = arr_hold[i];
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arr_val <= '0;
      for (int i = 0; i < NP; i++) begin
        arr_acc[i]  <= '0;
        arr_hold[i] <= '0;
        got_res[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NP; i++) begin
        if (pe_out_resp[i]) arr_val[i] <= 1'b0;
        if (pe_in_valid[i]) begin
          if (pe_store[i]) begin
            arr_hold[i] <= arr_acc[i] + CW'(pe_a) * CW'(pe_b);
            arr_acc[i]  <= '0;
            arr_val[i]  <= 1'b1;
          end else begin
            arr_acc[i] <= arr_acc[i] + CW'(pe_a) * CW'(pe_b);
          end
        end
      end
      if (res_valid && res_ready) got_res[res_idx] <= res_data;
    end
  end

  // Reference model: job phase, beats accepted, drain index, expected per-PE dot products.
  int            m_phase = 0;
  int            m_len = 1;
  int            m_beats = 0;
  int            m_idx = 0;
  logic [CW-1:0] m_res[NP];
  logic [NP-1:0] exp_in_valid = '0, exp_store = '0, exp_resp = '0;
  logic [DW-1:0] exp_a = '0, exp_b = '0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_phase = 0; m_beats = 0; m_idx = 0;
        exp_in_valid = '0; exp_store = '0; exp_resp = '0;
        exp_a = '0; exp_b = '0;
      end else begin
        automatic bit hs = (m_phase == 2) && pe_out_valid[m_idx] && (exp_resp == '0) && res_ready;
        automatic int p = m_beats % NP;
        automatic int t = m_beats / NP;
        exp_in_valid = '0; exp_store = '0; exp_resp = '0;
        case (m_phase)
          0: if (start) begin
               m_len = (vec_len == 0) ? 1 : int'(vec_len);
               m_beats = 0;
               m_phase = 1;
             end
          1: if (op_valid) begin
               exp_in_valid = NP'(1) << p;
               if (t == m_len - 1) exp_store = NP'(1) << p;
               exp_a = op_a;
               exp_b = op_b;
               if (t == 0) m_res[p] = CW'(op_a) * CW'(op_b);
               else        m_res[p] = m_res[p] + CW'(op_a) * CW'(op_b);
               m_beats++;
               if (m_beats == m_len * NP) begin
                 m_phase = 2;
                 m_idx = 0;
               end
             end
          2: if (hs) begin
               exp_resp = NP'(1) << m_idx;
               if (m_idx == NP - 1) m_phase = 3;
               else                 m_idx++;
             end
          default: m_phase = 0;
        endcase
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      begin
        automatic logic exp_rv = (m_phase == 2) && pe_out_valid[m_idx] && (exp_resp == '0);
        chk("busy", busy, m_phase != 0);
        chk("done", done, m_phase == 3);
        chk("op_ready", op_ready, m_phase == 1);
        chk("pe_in_valid", pe_in_valid, exp_in_valid);
        chk("pe_store", pe_store, exp_store);
        chk("pe_out_resp", pe_out_resp, exp_resp);
        chk("pe_a", pe_a, exp_a);
        chk("pe_b", pe_b, exp_b);
        chk("res_valid", res_valid, exp_rv);
        if (exp_rv) begin
          chk("res_idx", res_idx, m_idx);
          chk("res_data", res_data, m_res[m_idx]);
        end
      end
    end
  end

  logic [DW-1:0] ta[64];
  logic [DW-1:0] tb_[64];

  // vmode: 0 continuous, 1 toggling, 2 random. rmode: 0 ready, 1 random, 2 stall idx3 for 5 cycles.
  task automatic run_job(input int len, input int vmode, input int rmode,
                         input int start_at, input int abort_at);
    int total, n, guard, stall;
    bit hs, seen;
    total = ((len == 0) ? 1 : len) * NP;
    @(negedge clk);
    start = 1'b1;
    vec_len = LW'(len);
    @(negedge clk);
    start = 1'b0;
    vec_len = LW'($urandom);
    n = 0;
    guard = 0;
    while (n < total && guard < 2000) begin
      if (n == abort_at) begin
        op_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_op_ready", op_ready, 0);
        chk("rst_in_valid", pe_in_valid, 0);
        chk("rst_store", pe_store, 0);
        chk("rst_pe_a", pe_a, 0);
        chk("rst_pe_b", pe_b, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_resp", pe_out_resp, 0);
        repeat (2) @(negedge clk);
        #3 rst_n = 1'b1;
        return;
      end
      case (vmode)
        0:       op_valid = 1'b1;
        1:       op_valid = (guard % 2 == 0);
        default: op_valid = ($urandom_range(0, 2) != 0);
      endcase
      op_a = op_valid ? ta[n]  : DW'($urandom);
      op_b = op_valid ? tb_[n] : DW'($urandom);
      start = (n == start_at && guard < 2000);
      if (start) vec_len = 9;
      #1 hs = op_valid && op_ready;
      @(negedge clk);
      start = 1'b0;
      if (hs) n++;
      guard++;
    end
    op_valid = 1'b0;
    chk("feed_beats", n, total);
    guard = 0;
    stall = 0;
    seen = 0;
    while (!seen && guard < 500) begin
      case (rmode)
        0: res_ready = 1'b1;
        1: res_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (res_valid && res_idx == 3 && stall < 5) begin
            res_ready = 1'b0;
            stall++;
          end else begin
            res_ready = 1'b1;
          end
        end
      endcase
      #1 if (done) seen = 1;
      @(negedge clk);
      guard++;
    end
    res_ready = 1'b0;
    chk("done_seen", seen, 1);
    if (rmode == 2) chk("stall_cycles", stall, 5);
  endtask

  task automatic load_t1();
    for (int i = 0; i < 64; i++) begin
      ta[i]  = DW'(i + 1);
      tb_[i] = 8'd2;
    end
  endtask

  task automatic check_t1(input string tag);
    for (int i = 0; i < NP; i++) begin
      chk({tag, "_res"}, got_res[i], 2 * (i + 1));
      chk({tag, "_model"}, m_res[i], 2 * (i + 1));
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;

    load_t1();
    run_job(1, 0, 0, -1, -1);
    check_t1("t1");

    for (int i = 0; i < 64; i++) begin ta[i] = 8'd3; tb_[i] = 8'd3; end
    run_job(3, 0, 0, -1, -1);
    for (int i = 0; i < NP; i++) chk("t2_res", got_res[i], 27);

    load_t1();
    run_job(1, 1, 0, -1, -1);
    check_t1("t3");

    for (int i = 0; i < 64; i++) begin ta[i] = DW'($urandom); tb_[i] = DW'($urandom); end
    run_job(2, 2, 2, -1, -1);

    for (int i = 0; i < 64; i++) begin ta[i] = 8'd1; tb_[i] = 8'd1; end
    run_job(2, 0, 0, 5, -1);
    for (int i = 0; i < NP; i++) chk("t5_res", got_res[i], 2);

    for (int i = 0; i < 64; i++) begin ta[i] = DW'($urandom); tb_[i] = DW'($urandom); end
    run_job(2, 0, 0, -1, 10);
    load_t1();
    run_job(1, 0, 0, -1, -1);
    check_t1("t6");

    for (int j = 0; j < 6; j++) begin
      for (int i = 0; i < 64; i++) begin ta[i] = DW'($urandom); tb_[i] = DW'($urandom); end
      run_job($urandom_range(0, 4), 2, 1, -1, -1);
    end

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
